// File: rtl/clk_div_ctrl_pkg.sv
// Shared types and constants for the clk_div_ctrl programmable clock divider.
package clk_div_ctrl_pkg;

    localparam int DIV_W_DEF  = 8;
    localparam int EDGE_CNT_W = 16;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_STOP = 2'd2
    } state_e;

endpackage

// File: rtl/clk_div_ctrl_cnt.sv
// Half-period counter: holds the active ratio H, counts 0..H-1 and flags terminal count.
module clk_div_ctrl_cnt #(
    parameter int DIV_W = 8
) (
    input  logic             clk_i,
    input  logic             rst,
    input  logic             clr_i,
    input  logic             en_i,
    input  logic             load_i,
    input  logic [DIV_W-1:0] load_val_i,
    output logic             tc_o
);

    logic [DIV_W-1:0] h_q;
    logic [DIV_W-1:0] cnt_q;

    assign tc_o = (cnt_q == h_q - DIV_W'(1));

    always_ff @(posedge clk_i) begin
        if (rst) begin
            h_q   <= DIV_W'(1);
            cnt_q <= '0;
        end else begin
            if (load_i) begin
                h_q <= load_val_i;
            end
            // Wrap at terminal count so each toggle boundary restarts the half period.
            if (clr_i || (en_i && tc_o)) begin
                cnt_q <= '0;
            end else if (en_i) begin
                cnt_q <= cnt_q + DIV_W'(1);
            end
        end
    end

endmodule

// File: rtl/clk_div_ctrl.sv
// Glitch-free programmable clock divider with ratio handshake and graceful stop.
// Optional CLK_DIV_CTRL_EDGE_CNT_EN adds a 16-bit rising-edge counter output.
//
// state | meaning
// IDLE  | clk_o held low, ratio loads directly into H
// RUN   | clk_o toggling every H cycles, new ratios go to pending
// STOP  | en dropped during high phase, finishing it before IDLE
module clk_div_ctrl
    import clk_div_ctrl_pkg::*;
#(
    parameter int DIV_W = DIV_W_DEF
) (
    input  logic             clk_i,
    input  logic             rst,
    input  logic             en_i,
    input  logic             cfg_valid_i,
    input  logic [DIV_W-1:0] cfg_div_i,
    output logic             cfg_ready_o,
    output logic             clk_o,
    output logic             busy_o,
    output logic             err_o
`ifdef CLK_DIV_CTRL_EDGE_CNT_EN
    ,
    output logic [EDGE_CNT_W-1:0] edge_cnt_o
`endif
);

    localparam logic [1:0] IDLE = ST_IDLE;
    localparam logic [1:0] RUN  = ST_RUN;
    localparam logic [1:0] STOP = ST_STOP;

    logic [1:0]       state_q, state_nxt;
    logic             clk_nxt;
    logic             pend_vld_q;
    logic [DIV_W-1:0] pend_q;
    logic             tc;
    logic             cnt_clr, cnt_en;
    logic             h_load;
    logic [DIV_W-1:0] h_val;
    logic             hs, hs_legal, hs_zero;
    logic             fall_bnd, to_idle;

    assign cfg_ready_o = ~pend_vld_q;
    assign busy_o      = (state_q != IDLE);
    assign hs          = cfg_valid_i & cfg_ready_o;
    assign hs_legal    = hs & (cfg_div_i != '0);
    assign hs_zero     = hs & (cfg_div_i == '0);

    always_comb begin
        state_nxt = state_q;
        clk_nxt   = clk_o;
        cnt_clr   = 1'b0;
        cnt_en    = 1'b0;
        case (state_q)
            IDLE: begin
                clk_nxt = 1'b0;
                if (en_i) begin
                    state_nxt = RUN;
                    cnt_clr   = 1'b1;
                end
            end
            RUN: begin
                cnt_en = 1'b1;
                if (tc) begin
                    clk_nxt = ~clk_o;
                end
                if (!en_i) begin
                    if (!clk_o || tc) begin
                        state_nxt = IDLE;
                        clk_nxt   = 1'b0;
                        cnt_clr   = 1'b1;
                    end else begin
                        state_nxt = STOP;
                    end
                end
            end
            STOP: begin
                cnt_en = 1'b1;
                if (tc) begin
                    clk_nxt = 1'b0;
                    if (en_i) begin
                        state_nxt = RUN;
                    end else begin
                        state_nxt = IDLE;
                        cnt_clr   = 1'b1;
                    end
                end else if (en_i) begin
                    state_nxt = RUN;
                end
            end
            default: begin
                state_nxt = IDLE;
                clk_nxt   = 1'b0;
                cnt_clr   = 1'b1;
            end
        endcase
    end

    assign fall_bnd = (state_q != IDLE) & tc & clk_o;
    assign to_idle  = (state_q != IDLE) & (state_nxt == IDLE);

    // Ratio changes only take effect while clk_o is low, so no phase is ever shortened.
    always_comb begin
        h_load = 1'b0;
        h_val  = cfg_div_i;
        if (state_q == IDLE) begin
            h_load = hs_legal;
        end else if ((fall_bnd || to_idle) && pend_vld_q) begin
            h_load = 1'b1;
            h_val  = pend_q;
        end else if (to_idle && hs_legal) begin
            h_load = 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst) begin
            state_q    <= IDLE;
            clk_o      <= 1'b0;
            pend_vld_q <= 1'b0;
            pend_q     <= '0;
            err_o      <= 1'b0;
        end else begin
            state_q <= state_nxt;
            clk_o   <= clk_nxt;
            if (hs_zero) begin
                err_o <= 1'b1;
            end
            if ((fall_bnd || to_idle) && pend_vld_q) begin
                pend_vld_q <= 1'b0;
            end else if ((state_q != IDLE) && !to_idle && hs_legal) begin
                pend_vld_q <= 1'b1;
                pend_q     <= cfg_div_i;
            end
        end
    end

    clk_div_ctrl_cnt #(
        .DIV_W(DIV_W)
    ) u_cnt (
        .clk_i      (clk_i),
        .rst        (rst),
        .clr_i      (cnt_clr),
        .en_i       (cnt_en),
        .load_i     (h_load),
        .load_val_i (h_val),
        .tc_o       (tc)
    );

`ifdef CLK_DIV_CTRL_EDGE_CNT_EN
    always_ff @(posedge clk_i) begin
        if (rst) begin
            edge_cnt_o <= '0;
        end else if (clk_nxt && !clk_o) begin
            edge_cnt_o <= edge_cnt_o + EDGE_CNT_W'(1);
        end
    end
`endif

endmodule

// File: tb/tb_clk_div_ctrl.sv
// Directed self-checking bench for clk_div_ctrl: startup, ratio change, stop, illegal ratio, reset.
module tb_clk_div_ctrl;

    localparam int DIV_W = 8;

    logic             clk_i = 1'b0;
    logic             rst;
    logic             en_i;
    logic             cfg_valid_i;
    logic [DIV_W-1:0] cfg_div_i;
    logic             cfg_ready_o;
    logic             clk_o;
    logic             busy_o;
    logic             err_o;
`ifdef CLK_DIV_CTRL_EDGE_CNT_EN
    logic [15:0]      edge_cnt_o;
`endif

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk_i = ~clk_i;

    clk_div_ctrl #(
        .DIV_W(DIV_W)
    ) dut (
        .clk_i       (clk_i),
        .rst         (rst),
        .en_i        (en_i),
        .cfg_valid_i (cfg_valid_i),
        .cfg_div_i   (cfg_div_i),
        .cfg_ready_o (cfg_ready_o),
        .clk_o       (clk_o),
        .busy_o      (busy_o),
        .err_o       (err_o)
`ifdef CLK_DIV_CTRL_EDGE_CNT_EN
        ,
        .edge_cnt_o  (edge_cnt_o)
`endif
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    // Cycles until clk_o reaches lvl, bounded.
    task automatic wait_clk(input logic lvl, input string tag, input int exp_n);
        int n;
        n = 0;
        do begin
            tick();
            n++;
        end while (clk_o !== lvl && n < 64);
        check(tag, 32'(n), 32'(exp_n));
    endtask

    initial begin
        rst         = 1'b1;
        en_i        = 1'b0;
        cfg_valid_i = 1'b0;
        cfg_div_i   = '0;
        repeat (3) tick();
        check("rst_clk", 32'(clk_o), 32'd0);
        check("rst_ready", 32'(cfg_ready_o), 32'd1);
        check("rst_busy", 32'(busy_o), 32'd0);
        check("rst_err", 32'(err_o), 32'd0);

        // startup with H=3
        rst         = 1'b0;
        cfg_valid_i = 1'b1;
        cfg_div_i   = 8'd3;
        tick();
        cfg_valid_i = 1'b0;
        en_i        = 1'b1;
        tick();
        check("run_busy", 32'(busy_o), 32'd1);
        check("run_clk0", 32'(clk_o), 32'd0);
        wait_clk(1'b1, "first_rise", 3);
        wait_clk(1'b0, "h3_high", 3);
        wait_clk(1'b1, "h3_low", 3);

        // ratio change 3 -> 5 offered one cycle into high phase
        cfg_valid_i = 1'b1;
        cfg_div_i   = 8'd5;
        tick();
        cfg_valid_i = 1'b0;
        check("pend_ready", 32'(cfg_ready_o), 32'd0);
        wait_clk(1'b0, "rest_high", 2);
        check("ready_back", 32'(cfg_ready_o), 32'd1);
        wait_clk(1'b1, "h5_low", 5);
        wait_clk(1'b0, "h5_high", 5);

        // en drop while low -> straight to IDLE
        en_i = 1'b0;
        tick();
        check("direct_idle", 32'(busy_o), 32'd0);

        // stop during high phase with H=4
        cfg_valid_i = 1'b1;
        cfg_div_i   = 8'd4;
        tick();
        cfg_valid_i = 1'b0;
        en_i        = 1'b1;
        tick();
        wait_clk(1'b1, "h4_rise", 4);
        tick();
        en_i = 1'b0;
        tick();
        check("stop_busy", 32'(busy_o), 32'd1);
        check("stop_clk", 32'(clk_o), 32'd1);
        wait_clk(1'b0, "stop_fall", 2);
        check("stop_idle", 32'(busy_o), 32'd0);
        begin
            logic seen_high;
            seen_high = 1'b0;
            for (int i = 0; i < 8; i++) begin
                tick();
                if (clk_o !== 1'b0) seen_high = 1'b1;
            end
            check("idle_quiet", 32'(seen_high), 32'd0);
        end

        // illegal ratio in IDLE
        cfg_valid_i = 1'b1;
        cfg_div_i   = 8'd0;
        tick();
        cfg_valid_i = 1'b0;
        check("err_set", 32'(err_o), 32'd1);
        en_i = 1'b1;
        tick();
        wait_clk(1'b1, "h_kept_low", 4);
        wait_clk(1'b0, "h_kept_high", 4);
        check("err_sticky", 32'(err_o), 32'd1);
        en_i = 1'b0;
        tick();

        // pending H=2 and en drop in the same high phase
        en_i = 1'b1;
        tick();
        wait_clk(1'b1, "sim_rise", 4);
        cfg_valid_i = 1'b1;
        cfg_div_i   = 8'd2;
        en_i        = 1'b0;
        tick();
        cfg_valid_i = 1'b0;
        check("sim_ready", 32'(cfg_ready_o), 32'd0);
        check("sim_busy", 32'(busy_o), 32'd1);
        wait_clk(1'b0, "sim_fall", 3);
        check("sim_idle", 32'(busy_o), 32'd0);
        check("sim_ready1", 32'(cfg_ready_o), 32'd1);
        en_i = 1'b1;
        tick();
        wait_clk(1'b1, "h2_low", 2);
        wait_clk(1'b0, "h2_high", 2);
        wait_clk(1'b1, "h2_low2", 2);

        // reset mid high phase
        rst = 1'b1;
        tick();
        check("mid_rst_clk", 32'(clk_o), 32'd0);
        check("mid_rst_err", 32'(err_o), 32'd0);
        check("mid_rst_busy", 32'(busy_o), 32'd0);
        check("mid_rst_ready", 32'(cfg_ready_o), 32'd1);
        rst = 1'b0;
        tick();
        wait_clk(1'b1, "h1_low", 1);
        wait_clk(1'b0, "h1_high", 1);

`ifdef CLK_DIV_CTRL_EDGE_CNT_EN
        rst  = 1'b1;
        en_i = 1'b0;
        tick();
        check("ecnt_rst", 32'(edge_cnt_o), 32'd0);
        rst  = 1'b0;
        en_i = 1'b1;
        tick();
        begin
            int   rises;
            int   guard;
            logic prev;
            rises = 0;
            guard = 0;
            prev  = clk_o;
            while (rises < 65537 && guard < 140000) begin
                tick();
                guard++;
                if (clk_o && !prev) rises++;
                prev = clk_o;
            end
            check("ecnt_rises", 32'(rises), 32'd65537);
        end
        check("ecnt_wrap", 32'(edge_cnt_o), 32'h0001);
        rst = 1'b1;
        tick();
        check("ecnt_clr", 32'(edge_cnt_o), 32'd0);
        rst = 1'b0;
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/clk_div_ctrl.md
CLK_DIV_CTRL -- requirements
Module: clk_div_ctrl

Interface
REQ-001 Parameter DIV_W, default 8, width of the half-period ratio field.
REQ-002 clk_i  input  1  source clock; all logic on its rising edge.
REQ-003 rst  input  1  reset; synchronous, active-high.
REQ-004 en_i  input  1  run request for the divided clock (level).
REQ-005 cfg_valid_i  input  1  new ratio offered.
REQ-006 cfg_div_i  input  DIV_W  half-period in clk_i cycles (H); 0 illegal.
REQ-007 cfg_ready_o  output  1  ratio can be accepted this cycle.
REQ-008 clk_o  output  1  divided clock, registered, period 2*H clk_i cycles.
REQ-009 busy_o  output  1  state is not IDLE.
REQ-010 err_o  output  1  sticky: an illegal ratio (0) was accepted.

Function
REQ-011 States SHALL be IDLE, RUN and STOP; busy_o SHALL be 1 in RUN and STOP.
REQ-012 Handshake: transfer occurs when cfg_valid_i and cfg_ready_o are both 1 on a rising edge.
REQ-013 An accepted cfg_div_i of 0 SHALL leave the ratio unchanged and set err_o.
REQ-014 In IDLE, clk_o SHALL be 0, cfg_ready_o SHALL be 1, and an accepted legal ratio SHALL load into the active register H on the same edge.
REQ-015 IDLE->RUN when en_i=1; the counter SHALL clear on entry; the first clk_o rise SHALL occur H cycles after the entry edge.
REQ-016 In RUN, counter cnt SHALL count 0..H-1; at cnt=H-1, clk_o SHALL toggle and cnt SHALL return to 0 (a toggle boundary).
REQ-017 In RUN/STOP, a legal accepted ratio SHALL go to a pending register; cfg_ready_o SHALL drop the next cycle and stay 0 while pending.
REQ-018 Pending ratio SHALL become active only at a falling boundary (clk_o 1->0), with cnt cleared; cfg_ready_o SHALL return to 1 the following cycle.
REQ-019 RUN->STOP when en_i=0; if clk_o=0 at that point, the block SHALL go directly to IDLE instead.
REQ-020 In STOP, the block SHALL finish the high phase at the current H and go to IDLE at the falling boundary; en_i reasserting in STOP SHALL return to RUN without a clk_o glitch.
REQ-021 A pending ratio at a STOP->IDLE falling boundary SHALL be applied on that edge.
REQ-022 clk_o SHALL never show a high or low phase shorter than min(H_old, H_new) cycles.

Reset
REQ-023 On rst: state=IDLE, clk_o=0, cnt=0, H=1, pending cleared/discarded, cfg_ready_o=1, busy_o=0, err_o=0.
REQ-024 rst mid-operation SHALL force clk_o low on the next edge, whatever the phase.

Configuration
REQ-025 Macro CLK_DIV_CTRL_EDGE_CNT_EN SHALL, when defined, add output edge_cnt_o (16 bits): it counts clk_o 0->1 transitions, wraps 0xFFFF->0x0000 and is cleared by rst.
REQ-026 Without CLK_DIV_CTRL_EDGE_CNT_EN, the port and its counter SHALL be absent; all other behaviour is identical.

Structure
REQ-027 Package clk_div_ctrl_pkg SHALL hold the state enum, the DIV_W default and EDGE_CNT_W=16.
REQ-028 Sub-module clk_div_ctrl_cnt SHALL implement the half-period counter (load, clear, terminal-count flag); the FSM and handshake stay in clk_div_ctrl.

Verification
REQ-029 Reset: rst for 3 cycles, then load H=3 in IDLE, en_i=1 -> first clk_o rise 3 cycles after RUN entry; period 6 cycles; busy_o=1.
REQ-030 Ratio change: in RUN with H=3, offer 5 while clk_o=1 -> cfg_ready_o=0 next cycle; the remaining high phase stays 3; low phase then 5; ready returns 1 one cycle after the switch.
REQ-031 Stop: with H=4, drop en_i 1 cycle into the high phase -> clk_o falls 3 cycles later, state IDLE, busy_o=0; clk_o stays 0.
REQ-032 Illegal ratio: offer 0 in IDLE -> err_o=1 and stays 1; H unchanged (clk_o period still 2*old H); err_o cleared only by rst.
REQ-033 Simultaneous: pending H=2 plus en_i drop in the same high phase -> IDLE at that falling boundary with H=2; next en_i gives period 4.
REQ-034 With CLK_DIV_CTRL_EDGE_CNT_EN: H=1, run 65537 rises -> edge_cnt_o=0x0001; rst -> 0.
